// File: rtl/design_slot_sequencer.sv
// GPIO slot sequencer: selects one of NUM_DESIGNS designs to own the pads,
// with a select-stability filter and a break-before-make switch sequence.
module design_slot_sequencer #(
   parameter int NUM_DESIGNS   = 12,
   parameter int GPIO_W        = 34,
   parameter int SEL_W         = 4,
   parameter int STABLE_CYCLES = 4,
   parameter int GUARD_CYCLES  = 2,
   parameter int RESET_CYCLES  = 3
) (
   input  logic                          clk,
   input  logic                          n_rst,
   input  logic [SEL_W-1:0]              design_select,
   input  logic [GPIO_W-1:0]             gpio_in,
   input  logic [NUM_DESIGNS*GPIO_W-1:0] designs_gpio_out,
   input  logic [NUM_DESIGNS*GPIO_W-1:0] designs_gpio_oeb,
   output logic [GPIO_W-1:0]             gpio_out,
   output logic [GPIO_W-1:0]             gpio_oeb,
   output logic [NUM_DESIGNS-1:0]        designs_ncs,
   output logic [NUM_DESIGNS-1:0]        designs_n_rst,
   output logic [SEL_W-1:0]              active_design,
   output logic                          busy
);

   localparam int CNT_W   = $clog2(STABLE_CYCLES + 1);
   localparam int TMR_MAX = (GUARD_CYCLES > RESET_CYCLES) ?
                            GUARD_CYCLES : RESET_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   typedef enum logic [1:0] {
      S_OFF = 2'd0,
      S_ISO = 2'd1,
      S_RST = 2'd2,
      S_ACT = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   cur_q, cur_d;
   logic [SEL_W-1:0]   tgt_q, tgt_d;
   logic [SEL_W-1:0]   sel_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [SEL_W-1:0]   cand;
   logic               stable;
   logic               accept;

   logic [NUM_DESIGNS-1:0] ncs_q, ncs_d;
   logic [NUM_DESIGNS-1:0] nrst_q, nrst_d;
   logic [SEL_W-1:0]       act_q, act_d;
   logic                   busy_q, busy_d;

   // Pad inputs are fanned out outside this block.
   logic unused_gpio_in;
   assign unused_gpio_in = ^gpio_in;

   // Out-of-range selections collapse to "none".
   always_comb begin
      cand = '0;
      if (design_select >= SEL_W'(1) &&
          design_select <= SEL_W'(NUM_DESIGNS))
         cand = design_select;
   end

   // Stability counter; stable reflects the count being committed this edge.
   always_comb begin
      cnt_d = cnt_q;
      if (cand != sel_q)
         cnt_d = CNT_W'(1);
      else if (cnt_q != CNT_W'(STABLE_CYCLES))
         cnt_d = cnt_q + CNT_W'(1);
      stable = (cnt_d == CNT_W'(STABLE_CYCLES));
      accept = stable && (cand != cur_q) &&
               ((state_q == S_OFF) || (state_q == S_ACT));
   end

   // State, slot and timer registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= S_OFF;
         cur_q   <= '0;
         tgt_q   <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         tgt_q   <= tgt_d;
         sel_q   <= cand;
         cnt_q   <= cnt_d;
         tmr_q   <= tmr_d;
      end
   end

   // Next-state: break-before-make sequencing.
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      tgt_d   = tgt_q;
      tmr_d   = tmr_q;
      unique case (state_q)
         S_OFF: begin
            if (accept) begin
               tgt_d   = cand;
               state_d = S_RST;
               tmr_d   = TMR_W'(RESET_CYCLES - 1);
            end
         end
         S_ACT: begin
            if (accept) begin
               tgt_d   = cand;
               cur_d   = '0;
               state_d = S_ISO;
               tmr_d   = TMR_W'(GUARD_CYCLES - 1);
            end
         end
         S_ISO: begin
            if (tmr_q == '0) begin
               if (tgt_q != '0) begin
                  state_d = S_RST;
                  tmr_d   = TMR_W'(RESET_CYCLES - 1);
               end else begin
                  state_d = S_OFF;
               end
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         S_RST: begin
            if (tmr_q == '0) begin
               state_d = S_ACT;
               cur_d   = tgt_q;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         default: state_d = S_OFF;
      endcase
   end

   // Per-slot control derived from the next state, so outputs are registered.
   always_comb begin
      ncs_d  = '1;
      nrst_d = '0;
      act_d  = '0;
      busy_d = (state_d == S_ISO) || (state_d == S_RST);
      if (state_d == S_ACT)
         act_d = cur_d;
      for (int i = 0; i < NUM_DESIGNS; i++) begin
         if (state_d == S_RST && tgt_d == SEL_W'(i + 1))
            ncs_d[i] = 1'b0;
         if (state_d == S_ACT && cur_d == SEL_W'(i + 1)) begin
            ncs_d[i]  = 1'b0;
            nrst_d[i] = 1'b1;
         end
      end
   end

   // Registered slot controls and status.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ncs_q  <= '1;
         nrst_q <= '0;
         act_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         ncs_q  <= ncs_d;
         nrst_q <= nrst_d;
         act_q  <= act_d;
         busy_q <= busy_d;
      end
   end

   // Zero-latency pad mux, safe (tristated, low) unless a slot is active.
   always_comb begin
      gpio_out = '0;
      gpio_oeb = '1;
      if (state_q == S_ACT) begin
         for (int i = 0; i < NUM_DESIGNS; i++) begin
            if (cur_q == SEL_W'(i + 1)) begin
               gpio_out = designs_gpio_out[i*GPIO_W +: GPIO_W];
               gpio_oeb = designs_gpio_oeb[i*GPIO_W +: GPIO_W];
            end
         end
      end
   end

   assign designs_ncs   = ncs_q;
   assign designs_n_rst = nrst_q;
   assign active_design = act_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_design_slot_sequencer.sv
// Directed testbench for design_slot_sequencer.
// Walks switch, glitch, deselect, mid-sequence change and reset cases.
module tb_design_slot_sequencer;

   localparam int ND = 12;
   localparam int GW = 34;
   localparam int SW = 4;

   logic             clk;
   logic             n_rst;
   logic [SW-1:0]    design_select;
   logic [GW-1:0]    gpio_in;
   logic [ND*GW-1:0] designs_gpio_out;
   logic [ND*GW-1:0] designs_gpio_oeb;
   logic [GW-1:0]    gpio_out;
   logic [GW-1:0]    gpio_oeb;
   logic [ND-1:0]    designs_ncs;
   logic [ND-1:0]    designs_n_rst;
   logic [SW-1:0]    active_design;
   logic             busy;

   int n_chk;
   int n_err;

   localparam logic [GW-1:0] ONES = '1;

   design_slot_sequencer dut (
      .clk              (clk),
      .n_rst            (n_rst),
      .design_select    (design_select),
      .gpio_in          (gpio_in),
      .designs_gpio_out (designs_gpio_out),
      .designs_gpio_oeb (designs_gpio_oeb),
      .gpio_out         (gpio_out),
      .gpio_oeb         (gpio_oeb),
      .designs_ncs      (designs_ncs),
      .designs_n_rst    (designs_n_rst),
      .active_design    (active_design),
      .busy             (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [GW-1:0] pat_out(input int i);
      return {2'(i), 32'hA500_0000 + 32'(i) * 32'h0001_0101};
   endfunction

   function automatic logic [GW-1:0] pat_oeb(input int i);
      return {2'(~i), 32'h0F0F_0000 ^ (32'(i) * 32'h0000_0707)};
   endfunction

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         chk("inv_ncs", 64'($countones(~designs_ncs) <= 1), 64'd1);
         chk("inv_nrst", 64'(designs_n_rst & designs_ncs), 64'd0);
      end
   endtask

   task automatic chk_safe(input string tag);
      chk({tag, "_out"}, 64'(gpio_out), 64'd0);
      chk({tag, "_oeb"}, 64'(gpio_oeb), 64'(ONES));
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      n_rst = 1'b0;
      design_select = '0;
      gpio_in = '0;
      for (int i = 1; i <= ND; i++) begin
         designs_gpio_out[(i-1)*GW +: GW] = pat_out(i);
         designs_gpio_oeb[(i-1)*GW +: GW] = pat_oeb(i);
      end
      #23;
      chk("rst_ncs", 64'(designs_ncs), 64'hFFF);
      chk("rst_nrst", 64'(designs_n_rst), 64'h000);
      chk("rst_act", 64'(active_design), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk_safe("rst");
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      tick(6);
      chk("idle_ncs", 64'(designs_ncs), 64'hFFF);

      // OFF -> ACTIVE(3)
      design_select = 4'd3;
      tick(3);
      chk("t1_e3_busy", 64'(busy), 64'd0);
      tick(1);
      chk("t1_e4_ncs", 64'(designs_ncs), 64'hFFB);
      chk("t1_e4_busy", 64'(busy), 64'd1);
      chk("t1_e4_nrst", 64'(designs_n_rst), 64'h000);
      chk_safe("t1_e4");
      tick(3);
      chk("t1_e7_nrst", 64'(designs_n_rst), 64'h004);
      chk("t1_e7_ncs", 64'(designs_ncs), 64'hFFB);
      chk("t1_e7_act", 64'(active_design), 64'd3);
      chk("t1_e7_busy", 64'(busy), 64'd0);
      chk("t1_out", 64'(gpio_out), 64'(pat_out(3)));
      chk("t1_oeb", 64'(gpio_oeb), 64'(pat_oeb(3)));
      designs_gpio_out[2*GW +: GW] = 34'h2_1234_5678;
      #1;
      chk("t1_zlat", 64'(gpio_out), 64'h2_1234_5678);
      designs_gpio_out[2*GW +: GW] = pat_out(3);

      // ACTIVE(3) -> ACTIVE(5)
      design_select = 4'd5;
      tick(4);
      chk_safe("t2_e4");
      chk("t2_e4_nrst", 64'(designs_n_rst), 64'h000);
      chk("t2_e4_ncs", 64'(designs_ncs), 64'hFFF);
      chk("t2_e4_busy", 64'(busy), 64'd1);
      chk("t2_e4_act", 64'(active_design), 64'd0);
      tick(2);
      chk("t2_e6_ncs", 64'(designs_ncs), 64'hFEF);
      tick(3);
      chk("t2_e9_nrst", 64'(designs_n_rst), 64'h010);
      chk("t2_e9_act", 64'(active_design), 64'd5);
      chk("t2_out", 64'(gpio_out), 64'(pat_out(5)));

      // Glitch to 7 for 3 cycles
      design_select = 4'd7;
      for (int k = 0; k < 12; k++) begin
         tick(1);
         if (k == 2) design_select = 4'd5;
         chk("t3_ncs", 64'(designs_ncs), 64'hFEF);
         chk("t3_nrst", 64'(designs_n_rst), 64'h010);
         chk("t3_out", 64'(gpio_out), 64'(pat_out(5)));
      end

      // Go to ACTIVE(2), then deselect with 14
      design_select = 4'd2;
      tick(9);
      chk("t4_act2", 64'(active_design), 64'd2);
      design_select = 4'd14;
      tick(4);
      chk("t4_e4_busy", 64'(busy), 64'd1);
      chk_safe("t4_e4");
      tick(2);
      chk("t4_e6_busy", 64'(busy), 64'd0);
      chk("t4_e6_act", 64'(active_design), 64'd0);
      chk("t4_e6_nrst", 64'(designs_n_rst), 64'h000);
      chk("t4_e6_ncs", 64'(designs_ncs), 64'hFFF);
      chk_safe("t4_e6");
      tick(4);
      chk("t4_off_busy", 64'(busy), 64'd0);

      // ACTIVE(1), then 4 with change to 9 mid-sequence
      design_select = 4'd1;
      tick(7);
      chk("t5_act1", 64'(active_design), 64'd1);
      design_select = 4'd4;
      tick(4);
      chk("t5_e4_busy", 64'(busy), 64'd1);
      tick(1);
      design_select = 4'd9;
      tick(1);
      chk("t5_e6_ncs", 64'(designs_ncs), 64'hFF7);
      tick(3);
      chk("t5_e9_act", 64'(active_design), 64'd4);
      chk("t5_e9_nrst", 64'(designs_n_rst), 64'h008);
      tick(1);
      chk("t5_e10_busy", 64'(busy), 64'd1);
      chk("t5_e10_act", 64'(active_design), 64'd0);
      tick(2);
      chk("t5_e12_ncs", 64'(designs_ncs), 64'hEFF);
      tick(3);
      chk("t5_e15_act", 64'(active_design), 64'd9);
      chk("t5_e15_nrst", 64'(designs_n_rst), 64'h100);
      chk("t5_out", 64'(gpio_out), 64'(pat_out(9)));

      // Reset during RST(6)
      design_select = 4'd6;
      tick(6);
      chk("t6_rst6_ncs", 64'(designs_ncs), 64'hFDF);
      tick(1);
      n_rst = 1'b0;
      #1;
      chk("t6_ar_ncs", 64'(designs_ncs), 64'hFFF);
      chk("t6_ar_nrst", 64'(designs_n_rst), 64'h000);
      chk("t6_ar_busy", 64'(busy), 64'd0);
      chk("t6_ar_act", 64'(active_design), 64'd0);
      chk_safe("t6_ar");
      @(posedge clk);
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      tick(3);
      chk("t6_e3_ncs", 64'(designs_ncs), 64'hFFF);
      tick(1);
      chk("t6_e4_ncs", 64'(designs_ncs), 64'hFDF);
      tick(3);
      chk("t6_e7_act", 64'(active_design), 64'd6);
      chk("t6_e7_nrst", 64'(designs_n_rst), 64'h020);
      chk("t6_out", 64'(gpio_out), 64'(pat_out(6)));
      chk("t6_oeb", 64'(gpio_oeb), 64'(pat_oeb(6)));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
